ysyx_25060170_mem_arb: RTL and testbench

Two-requester memory arbiter and transaction sequencer for the single-issue core. It is the only path from the IFU instruction-fetch port and the LSU load/store port to one shared memory bus. Each side uses valid/ready request and response channels. It grants one requester at a time using round-robin, registers the granted request, and drives it onto the memory bus. It then routes the single response back to the owner before accepting the next request.

---
 rtl/ysyx_25060170_bus_pkg.sv | 24 ++
 rtl/ysyx_25060170_mem_arb_if.sv | 58 +++++
 rtl/ysyx_25060170_rr_arb2.sv | 26 ++
 rtl/ysyx_25060170_mem_arb.sv | 140 ++++++++++++++
 tb/tb_ysyx_25060170_mem_arb.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_bus_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids,
// access sizes and default widths/watchdog limit.
package ysyx_25060170_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/ysyx_25060170_mem_arb_if.sv
// Bundle of the IFU, LSU and memory-side channels seen by the arbiter.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; the valid side holds its payload stable until then.
interface ysyx_25060170_mem_arb_if #(
  parameter int ADDR_W = ysyx_25060170_bus_pkg::ADDR_W_DEF,
  parameter int DATA_W = ysyx_25060170_bus_pkg::DATA_W_DEF
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_req_addr;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_W-1:0]     ifu_resp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_wen;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic [1:0]            lsu_req_size;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_W-1:0]     lsu_resp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic [1:0]            mem_req_size;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_W-1:0]     mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
    input  lsu_req_wmask, lsu_req_size, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    output mem_req_wmask, mem_req_size, mem_resp_ready
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
    output lsu_req_wmask, lsu_req_size, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    input  mem_req_wmask, mem_req_size, mem_resp_ready
  );

endinterface

// File: rtl/ysyx_25060170_rr_arb2.sv
// Two-input round-robin grant; on contention the requester that did not own
// the previous transaction wins. last_owner is held by the parent.
module ysyx_25060170_rr_arb2
  import ysyx_25060170_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_owner_i,
  output logic [1:0] grant_o,
  output owner_t     grant_id_o
);

  always_comb begin
    grant_id_o = OWN_IFU;
    grant_o    = 2'b00;
    case (req_i)
      2'b01:   grant_id_o = OWN_IFU;
      2'b10:   grant_id_o = OWN_LSU;
      2'b11:   grant_id_o = (last_owner_i == OWN_IFU) ? OWN_LSU : OWN_IFU;
      default: grant_id_o = OWN_IFU;
    endcase
    if (|req_i) begin
      grant_o = (grant_id_o == OWN_LSU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_25060170_mem_arb.sv
// IFU/LSU to shared memory bus arbiter: one outstanding transaction, request
// registered in REQ, response routed to its owner in RESP, sticky watchdog.
module ysyx_25060170_mem_arb
  import ysyx_25060170_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_25060170_mem_arb_if.slave bus,
  output logic                   busy_o,
  output logic                   timeout_o,
  output state_t                 dbg_state_o
);

  localparam int MW    = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, r_last_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MW-1:0]     r_wmask;
  logic [1:0]        r_size;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_timeout;

  logic [1:0]        w_req, w_grant;
  owner_t            w_grant_id;
  logic              w_idle, w_hs, w_counting, w_owner_rdy;

  assign w_req = {bus.lsu_req_valid, bus.ifu_req_valid};

  ysyx_25060170_rr_arb2 u_rr_arb2 (
    .req_i        (w_req),
    .last_owner_i (r_last_owner),
    .grant_o      (w_grant),
    .grant_id_o   (w_grant_id)
  );

  assign w_idle            = (r_state == ST_IDLE);
  assign bus.ifu_req_ready = w_idle & w_grant[0];
  assign bus.lsu_req_ready = w_idle & w_grant[1];
  assign w_hs              = w_idle & (|w_grant);
  assign w_owner_rdy       = (r_owner == OWN_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.mem_resp_ready = w_owner_rdy;
        bus.ifu_resp_valid = (r_owner == OWN_IFU) & bus.mem_resp_valid;
        bus.lsu_resp_valid = (r_owner == OWN_LSU) & bus.mem_resp_valid;
        if (bus.mem_resp_valid && w_owner_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fetches are always word reads, so their write-side fields are forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_IFU;
      r_last_owner <= OWN_LSU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_size       <= 2'd0;
    end else if (w_hs) begin
      r_owner      <= w_grant_id;
      r_last_owner <= w_grant_id;
      if (w_grant_id == OWN_IFU) begin
        r_addr  <= bus.ifu_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
        r_size  <= SZ_W;
      end else begin
        r_addr  <= bus.lsu_req_addr;
        r_wen   <= bus.lsu_req_wen;
        r_wdata <= bus.lsu_req_wdata;
        r_wmask <= bus.lsu_req_wmask;
        r_size  <= bus.lsu_req_size;
      end
    end
  end

  assign w_counting = (r_state == ST_REQ) || (r_state == ST_RESP);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_hs)                                       w_cnt_nxt = '0;
    else if (w_counting && (r_cnt != {CNT_W{1'b1}})) w_cnt_nxt = r_cnt + 1'b1;
  end

  // The watchdog only flags; the transaction keeps waiting for the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if ((TIMEOUT != 0) && (w_cnt_nxt == TMO)) r_timeout <= 1'b1;
    end
  end

  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;
  assign bus.mem_req_size  = r_size;
  assign bus.ifu_resp_data = bus.mem_resp_data;
  assign bus.lsu_resp_data = bus.mem_resp_data;

  assign busy_o      = (r_state != ST_IDLE);
  assign timeout_o   = r_timeout;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios plus a random
// back-to-back run, with request and response expectations held in queues.
module tb_ysyx_25060170_mem_arb;
  import ysyx_25060170_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int RW = AW + 1 + DW + MW + 2;

  logic   clk = 1'b0;
  logic   rst;
  logic   busy, tmo;
  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] exp_req_q[$];

  always #5 clk = ~clk;

  ysyx_25060170_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ysyx_25060170_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_o      (busy),
    .timeout_o   (tmo),
    .dbg_state_o (dbg_state)
  );

  function automatic logic [RW-1:0] pack_req(input logic [AW-1:0] a, input logic w,
                                             input logic [DW-1:0] d, input logic [MW-1:0] m,
                                             input logic [1:0] s);
    return {a, w, d, m, s};
  endfunction

  function automatic logic [RW-1:0] dut_req();
    return {bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask, bus.mem_req_size};
  endfunction

  // ---------------- clock / reset / driver tasks ----------------
  task automatic drive_idle();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_resp_ready = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.lsu_req_size   = 2'd0;
    bus.lsu_resp_ready = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  // Each cycle: inputs driven at posedge+1, outputs checked at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic [MW-1:0] m, input logic [1:0] s);
    bus.lsu_req_addr  = a;
    bus.lsu_req_wen   = w;
    bus.lsu_req_wdata = d;
    bus.lsu_req_wmask = m;
    bus.lsu_req_size  = s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.mem_resp_valid = 1'b1;
    bus.ifu_resp_ready = 1'b1;
    settle();
    checks++;
    if ({bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid, busy, tmo} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b required 000000",
               {bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid, busy, tmo});
    end
    checks++;
    if (dut_req() !== '0) begin
      failures++;
      $display("FAIL reset_fields: got %h required 0", dut_req());
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_ifu_fetch();
    logic [DW-1:0] d;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = 32'h8000_0000;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    drive_lsu(32'h1111_2222, 1'b1, 32'h3333_4444, 4'hF, 2'd1);
    settle();
    checks++;
    if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL fetch_grant: got %b required 01", {bus.lsu_req_ready, bus.ifu_req_ready});
    end
    exp_req_q.push_back(pack_req(32'h8000_0000, 1'b0, '0, '0, SZ_W));
    exp_q.push_back(32'h0000_0413);
    next_cycle();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    checks++;
    if (bus.mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_memreq_cycle1: got valid=%b busy=%b required 1 1", bus.mem_req_valid, busy);
    end
    checks++;
    if (dut_req() !== exp_req_q[0]) begin
      failures++;
      $display("FAIL fetch_fields: got %h required %h", dut_req(), exp_req_q[0]);
    end
    void'(exp_req_q.pop_front());
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0413;
    settle();
    checks++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_resp_ready} !== 3'b101) begin
      failures++;
      $display("FAIL fetch_resp_cycle2: got %b required 101", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_resp_ready});
    end
    d = exp_q.pop_front();
    checks++;
    if (bus.ifu_resp_data !== d) begin
      failures++;
      $display("FAIL fetch_data: got %h required %h", bus.ifu_resp_data, d);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL fetch_idle_cycle3: got busy=%b state=%0d required 0 0", busy, dbg_state);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    owner_t        exp_own;
    logic [DW-1:0] d;
    logic [DW-1:0] got;
    apply_reset();
    exp_own            = OWN_IFU;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = 32'h8000_1000;
    bus.lsu_req_valid  = 1'b1;
    drive_lsu(32'h8000_2000, 1'b0, 32'h0, 4'h0, SZ_W);
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if ({bus.lsu_req_ready, bus.ifu_req_ready} !== ((exp_own == OWN_IFU) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL alt_grant[%0d]: got %b required owner %0d", k, {bus.lsu_req_ready, bus.ifu_req_ready}, exp_own);
      end
      d = $urandom;
      exp_q.push_back(d);
      exp_req_q.push_back((exp_own == OWN_IFU) ? pack_req(32'h8000_1000, 1'b0, '0, '0, SZ_W)
                                               : pack_req(32'h8000_2000, 1'b0, '0, '0, SZ_W));
      next_cycle();
      bus.mem_req_ready = 1'b1;
      settle();
      checks++;
      if ({bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b100 || dut_req() !== exp_req_q[0]) begin
        failures++;
        $display("FAIL alt_memreq[%0d]: got v/r=%b fields=%h required 100 %h", k,
                 {bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready}, dut_req(), exp_req_q[0]);
      end
      void'(exp_req_q.pop_front());
      next_cycle();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = d;
      settle();
      checks++;
      if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !==
          ((exp_own == OWN_IFU) ? 4'b1000 : 4'b0100)) begin
        failures++;
        $display("FAIL alt_resp[%0d]: got %b required owner %0d only", k,
                 {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready}, exp_own);
      end
      got = (exp_own == OWN_IFU) ? bus.ifu_resp_data : bus.lsu_resp_data;
      d   = exp_q.pop_front();
      checks++;
      if (got !== d) begin
        failures++;
        $display("FAIL alt_data[%0d]: got %h required %h", k, got, d);
      end
      next_cycle();
      bus.mem_resp_valid = 1'b0;
      exp_own = (exp_own == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_store_stall();
    logic [DW-1:0] d;
    bus.lsu_req_valid  = 1'b1;
    drive_lsu(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, SZ_W);
    bus.lsu_resp_ready = 1'b1;
    settle();
    checks++;
    if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL store_grant: got %b required 10", {bus.lsu_req_ready, bus.ifu_req_ready});
    end
    exp_req_q.push_back(pack_req(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF, SZ_W));
    exp_q.push_back(32'hA5A5_0001);
    next_cycle();
    bus.lsu_req_valid = 1'b0;
    drive_lsu(32'h0BAD_0BAD, 1'b0, 32'h0, 4'h1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready  = (i == 3);
      bus.mem_resp_valid = (i == 1);
      settle();
      checks++;
      if (bus.mem_req_valid !== 1'b1 || dut_req() !== exp_req_q[0]) begin
        failures++;
        $display("FAIL store_hold[%0d]: got v=%b fields=%h required 1 %h", i, bus.mem_req_valid, dut_req(), exp_req_q[0]);
      end
      checks++;
      if ({bus.mem_resp_ready, bus.lsu_resp_valid, bus.ifu_resp_valid} !== 3'b000) begin
        failures++;
        $display("FAIL store_early_resp[%0d]: got %b required 000", i,
                 {bus.mem_resp_ready, bus.lsu_resp_valid, bus.ifu_resp_valid});
      end
      if (i == 3) void'(exp_req_q.pop_front());
      next_cycle();
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hA5A5_0001;
    settle();
    d = exp_q.pop_front();
    checks++;
    if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_resp_ready} !== 3'b101 || bus.lsu_resp_data !== d) begin
      failures++;
      $display("FAIL store_ack: got %b data=%h required 101 %h",
               {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_resp_ready}, bus.lsu_resp_data, d);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL store_done: got busy=%b required 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_load_backpressure();
    logic [DW-1:0] d;
    bus.lsu_req_valid  = 1'b1;
    drive_lsu(32'h8000_0200, 1'b0, 32'h0, 4'h0, SZ_W);
    bus.lsu_resp_ready = 1'b0;
    settle();
    exp_req_q.push_back(pack_req(32'h8000_0200, 1'b0, '0, '0, SZ_W));
    exp_q.push_back(32'h1234_5678);
    next_cycle();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    checks++;
    if (bus.mem_req_valid !== 1'b1 || dut_req() !== exp_req_q[0]) begin
      failures++;
      $display("FAIL load_memreq: got v=%b fields=%h required 1 %h", bus.mem_req_valid, dut_req(), exp_req_q[0]);
    end
    void'(exp_req_q.pop_front());
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({bus.mem_resp_ready, bus.lsu_resp_valid, busy} !== 3'b011) begin
        failures++;
        $display("FAIL load_stall[%0d]: got %b required 011", i, {bus.mem_resp_ready, bus.lsu_resp_valid, busy});
      end
      next_cycle();
    end
    bus.lsu_resp_ready = 1'b1;
    settle();
    d = exp_q.pop_front();
    checks++;
    if ({bus.mem_resp_ready, bus.lsu_resp_valid} !== 2'b11 || bus.lsu_resp_data !== d) begin
      failures++;
      $display("FAIL load_deliver: got %b data=%h required 11 %h", {bus.mem_resp_ready, bus.lsu_resp_valid}, bus.lsu_resp_data, d);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done: got busy=%b required 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    apply_reset();
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = 32'h8000_0040;
    bus.ifu_resp_ready = 1'b1;
    settle();
    checks++;
    if (tmo !== 1'b0 || bus.ifu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL tmo_start: got tmo=%b rdy=%b required 0 1", tmo, bus.ifu_req_ready);
    end
    exp_req_q.push_back(pack_req(32'h8000_0040, 1'b0, '0, '0, SZ_W));
    exp_q.push_back(32'hCAFE_F00D);
    next_cycle();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    checks++;
    if (dut_req() !== exp_req_q[0]) begin
      failures++;
      $display("FAIL tmo_fields: got %h required %h", dut_req(), exp_req_q[0]);
    end
    void'(exp_req_q.pop_front());
    next_cycle();
    bus.mem_req_ready = 1'b0;
    for (int i = 2; i < 8; i++) begin
      settle();
      checks++;
      if (tmo !== (i >= 5) || bus.ifu_resp_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL tmo_cycle[%0d]: got tmo=%b rv=%b busy=%b required %b 0 1", i, tmo, bus.ifu_resp_valid, busy, (i >= 5));
      end
      next_cycle();
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFE_F00D;
    settle();
    d = exp_q.pop_front();
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_resp_data !== d || tmo !== 1'b1) begin
      failures++;
      $display("FAIL tmo_late_resp: got rv=%b data=%h tmo=%b required 1 %h 1", bus.ifu_resp_valid, bus.ifu_resp_data, tmo, d);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || tmo !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky: got busy=%b tmo=%b required 0 1", busy, tmo);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = 32'h8000_0300;
    bus.ifu_resp_ready = 1'b0;
    settle();
    exp_req_q.push_back(pack_req(32'h8000_0300, 1'b0, '0, '0, SZ_W));
    next_cycle();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    checks++;
    if (dut_req() !== exp_req_q[0]) begin
      failures++;
      $display("FAIL rstmid_fields: got %h required %h", dut_req(), exp_req_q[0]);
    end
    void'(exp_req_q.pop_front());
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5555_AAAA;
    settle();
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || dbg_state !== ST_RESP) begin
      failures++;
      $display("FAIL rstmid_in_resp: got rv=%b state=%0d required 1 %0d", bus.ifu_resp_valid, dbg_state, ST_RESP);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid, busy, tmo} !== 6'b0 ||
        dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rstmid_async: got %b state=%0d required 000000 0",
               {bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid, busy, tmo}, dbg_state);
    end
    bus.mem_resp_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = 32'h8000_0400;
    bus.ifu_resp_ready = 1'b1;
    settle();
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_regrant: got rdy=%b required 1", bus.ifu_req_ready);
    end
    exp_req_q.push_back(pack_req(32'h8000_0400, 1'b0, '0, '0, SZ_W));
    exp_q.push_back(32'h0000_0013);
    next_cycle();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    checks++;
    if (bus.mem_req_valid !== 1'b1 || dut_req() !== exp_req_q[0]) begin
      failures++;
      $display("FAIL rstmid_newreq: got v=%b fields=%h required 1 %h", bus.mem_req_valid, dut_req(), exp_req_q[0]);
    end
    void'(exp_req_q.pop_front());
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0013;
    settle();
    d = exp_q.pop_front();
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_resp_data !== d) begin
      failures++;
      $display("FAIL rstmid_newresp: got rv=%b data=%h required 1 %h", bus.ifu_resp_valid, bus.ifu_resp_data, d);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    owner_t        tb_last, g;
    logic          iv, lv, any;
    logic [AW-1:0] ia;
    logic [DW-1:0] d, got;
    apply_reset();
    tb_last = OWN_LSU;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      ia = $urandom;
      bus.ifu_req_valid = iv;
      bus.ifu_req_addr  = ia;
      bus.lsu_req_valid = lv;
      drive_lsu($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      any = iv | lv;
      g   = OWN_IFU;
      if (iv && lv) g = (tb_last == OWN_IFU) ? OWN_LSU : OWN_IFU;
      else if (lv)  g = OWN_LSU;
      settle();
      checks++;
      if ({bus.lsu_req_ready, bus.ifu_req_ready} !== (!any ? 2'b00 : (g == OWN_LSU) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL b2b_grant[%0d]: got %b req=%b%b last=%0d", n, {bus.lsu_req_ready, bus.ifu_req_ready}, lv, iv, tb_last);
      end
      if (!any) begin
        next_cycle();
        continue;
      end
      exp_req_q.push_back((g == OWN_IFU) ? pack_req(ia, 1'b0, '0, '0, SZ_W)
                                         : pack_req(bus.lsu_req_addr, bus.lsu_req_wen, bus.lsu_req_wdata,
                                                    bus.lsu_req_wmask, bus.lsu_req_size));
      d = $urandom;
      exp_q.push_back(d);
      tb_last = g;
      next_cycle();
      bus.ifu_req_valid = 1'($urandom_range(0, 1));
      bus.lsu_req_valid = 1'($urandom_range(0, 1));
      bus.mem_req_ready = 1'b1;
      settle();
      checks++;
      if ({bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b100 || dut_req() !== exp_req_q[0]) begin
        failures++;
        $display("FAIL b2b_memreq[%0d]: got v/r=%b fields=%h required 100 %h", n,
                 {bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready}, dut_req(), exp_req_q[0]);
      end
      void'(exp_req_q.pop_front());
      next_cycle();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = d;
      settle();
      got = (g == OWN_IFU) ? bus.ifu_resp_data : bus.lsu_resp_data;
      d   = exp_q.pop_front();
      checks++;
      if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !==
          ((g == OWN_IFU) ? 4'b1000 : 4'b0100) || got !== d) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: got %b data=%h required owner %0d data %h", n,
                 {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready}, got, g, d);
      end
      next_cycle();
      bus.mem_resp_valid = 1'b0;
    end
    drive_idle();
    next_cycle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_ifu_fetch();
    test_alternate();
    test_store_stall();
    test_load_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0 || exp_req_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left required 0/0", exp_q.size(), exp_req_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got no completion required finish before 500000");
    $fatal(1, "time limit");
  end

endmodule
